sprite_ram_arbiter: RTL

Shares the single-port synchronous sprite attribute RAM (64 x 16, `RAM_sync`) between the CPU/game-logic port and the sprite scanline renderer's sprite-load port. The renderer owns the RAM during its sprite-load window and whenever it raises its busy flag. CPU reads and writes are sequenced through a small state machine with a req/ack handshake. The block sits between the renderer, the CPU-side logic and the RAM in the top level, and replaces the direct RAM hookup.

---
 rtl/sprite_ram_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sprite_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_ram_arbiter                                                   |
// | Shares the sprite attribute RAM between the renderer and the CPU.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sprite_ram_arbiter #(
    parameter int unsigned AW       = 6,
    parameter int unsigned DW       = 16,
    parameter int unsigned WIN_LINE = 260,
    parameter int unsigned WIN_LEN  = 264
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    hpos,
    input  logic [8:0]    vpos,
    input  logic [AW-1:0] rnd_addr,
    input  logic          rnd_busy,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic [7:0]    conflict_cnt
);

    localparam logic [8:0] c_WIN_LINE = 9'(WIN_LINE);
    localparam logic [8:0] c_WIN_LEN  = 9'(WIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_ADDR = 2'd1,
        S_RD_DATA = 2'd2,
        S_WR      = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_ack;
    logic [DW-1:0] r_rdata;
    logic [7:0]    r_conflict_cnt;

    logic w_blackout;
    logic w_pending;
    logic w_accept;
    logic w_stall;
    logic w_frame_start;

    assign w_blackout    = rnd_busy | ((vpos == c_WIN_LINE) & (hpos < c_WIN_LEN));
    // A request still held during its own ack cycle must not start a second access.
    assign w_pending     = (r_state == S_IDLE) & cpu_req & ~r_ack;
    assign w_accept      = w_pending & ~w_blackout;
    assign w_stall       = w_pending & w_blackout;
    assign w_frame_start = (vpos == 9'd0) & (hpos == 9'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_ack          <= 1'b0;
            r_rdata        <= '0;
            r_conflict_cnt <= 8'd0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_state <= cpu_we ? S_WR : S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    r_rdata <= ram_dout;
                    r_ack   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_WR: begin
                    r_ack   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_frame_start) begin
                r_conflict_cnt <= 8'd0;
            end else if (w_stall && (r_conflict_cnt != 8'hFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end
    end

    // The renderer's address passes straight through whenever no CPU access is in flight.
    always_comb begin
        ram_addr = rnd_addr;
        ram_din  = '0;
        ram_we   = 1'b0;
        case (r_state)
            S_RD_ADDR, S_RD_DATA: begin
                ram_addr = r_addr;
            end
            S_WR: begin
                ram_addr = r_addr;
                ram_din  = r_wdata;
                ram_we   = 1'b1;
            end
            default: begin
                ram_addr = rnd_addr;
            end
        endcase
    end

    assign cpu_ack      = r_ack;
    assign cpu_rdata    = r_rdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire
